// File: rtl/hq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hq_pkg                                                               |
// | Shared widths, FSM encoding and row-extraction helper for HqB2.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package hq_pkg;

   localparam int HQ_DW   = 16;
   localparam int HQ_ROWS = 4;
   localparam int HQ_COLS = 2;

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_STREAM = 1'b1
   } hq_state_t;

   // Row 0 occupies the most significant element of a packed column word.
   function automatic logic [HQ_DW-1:0] hq_row(input logic [HQ_ROWS*HQ_DW-1:0] word,
                                               input logic [1:0]               k);
      return word[HQ_DW*(HQ_ROWS-1-int'(k)) +: HQ_DW];
   endfunction

endpackage : hq_pkg
`default_nettype wire

// File: rtl/hq_col_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hq_col_buffer                                                        |
// | Capture-enabled 4x64-bit column bank with (col,row) element select.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hq_col_buffer
   import hq_pkg::*;
#(
   parameter int DW   = HQ_DW,
   parameter int ROWS = HQ_ROWS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cap,
   input  logic [ROWS*DW-1:0] col0_r,
   input  logic [ROWS*DW-1:0] col0_i,
   input  logic [ROWS*DW-1:0] col1_r,
   input  logic [ROWS*DW-1:0] col1_i,
   input  logic               sel_col,
   input  logic [1:0]         sel_row,
   output logic [DW-1:0]      out_r,
   output logic [DW-1:0]      out_i
);

   logic [ROWS*DW-1:0] r_c0r, r_c0i, r_c1r, r_c1i;
   logic [ROWS*DW-1:0] w_word_r, w_word_i;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_c0r <= '0;
         r_c0i <= '0;
         r_c1r <= '0;
         r_c1i <= '0;
      end else if (cap) begin
         r_c0r <= col0_r;
         r_c0i <= col0_i;
         r_c1r <= col1_r;
         r_c1i <= col1_i;
      end
   end

   always_comb begin
      w_word_r = sel_col ? r_c1r : r_c0r;
      w_word_i = sel_col ? r_c1i : r_c0i;
      out_r    = hq_row(w_word_r, sel_row);
      out_i    = hq_row(w_word_i, sel_row);
   end

endmodule : hq_col_buffer
`default_nettype wire

// File: rtl/hq_col_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hq_col_reader                                                        |
// | Captures a 2-column complex frame on col_ready rise and streams it.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hq_col_reader
   import hq_pkg::*;
#(
   parameter int DW   = HQ_DW,
   parameter int ROWS = HQ_ROWS,
   parameter int COLS = HQ_COLS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ROWS*DW-1:0] col0_r,
   input  logic [ROWS*DW-1:0] col0_i,
   input  logic [ROWS*DW-1:0] col1_r,
   input  logic [ROWS*DW-1:0] col1_i,
   input  logic               col_ready,
   output logic [DW-1:0]      smp_r,
   output logic [DW-1:0]      smp_i,
   output logic               smp_col,
   output logic [1:0]         smp_row,
   output logic               smp_valid,
   input  logic               smp_ready,
   output logic               frame_done,
   output logic               busy,
   output logic               overrun
);

   localparam int              c_IW   = $clog2(ROWS*COLS);
   localparam logic [c_IW-1:0] c_LAST = c_IW'(ROWS*COLS-1);
   localparam logic [c_IW-1:0] c_ONE  = c_IW'(1);

   hq_state_t       r_state, w_state_nxt;
   logic [c_IW-1:0] r_idx, w_idx_nxt;
   logic            r_rdy_q;
   logic            w_rise, w_capture, w_last, w_ovr;
   logic [DW-1:0]   w_buf_r, w_buf_i, w_nxt_r, w_nxt_i;

   assign w_rise = col_ready & ~r_rdy_q;

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_capture   = 1'b0;
      w_last      = 1'b0;
      w_ovr       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_rise) begin
               w_capture   = 1'b1;
               w_idx_nxt   = '0;
               w_state_nxt = S_STREAM;
            end
         end
         S_STREAM: begin
            if (smp_ready) begin
               w_idx_nxt = r_idx + c_ONE;
               if (r_idx == c_LAST) begin
                  w_last = 1'b1;
                  // A rise on the final handshake chains straight into the next frame.
                  if (w_rise) begin
                     w_capture = 1'b1;
                     w_idx_nxt = '0;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end
            end
            w_ovr = w_rise & ~w_last;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   hq_col_buffer #(
      .DW   (DW),
      .ROWS (ROWS)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .cap     (w_capture),
      .col0_r  (col0_r),
      .col0_i  (col0_i),
      .col1_r  (col1_r),
      .col1_i  (col1_i),
      .sel_col (w_idx_nxt[c_IW-1]),
      .sel_row (w_idx_nxt[1:0]),
      .out_r   (w_buf_r),
      .out_i   (w_buf_i)
   );

   // Element 0 of a freshly captured frame bypasses the bank, which loads on the same edge.
   assign w_nxt_r = w_capture ? hq_row(col0_r, 2'd0) : w_buf_r;
   assign w_nxt_i = w_capture ? hq_row(col0_i, 2'd0) : w_buf_i;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_rdy_q    <= 1'b0;
         smp_r      <= '0;
         smp_i      <= '0;
         smp_col    <= 1'b0;
         smp_row    <= 2'd0;
         smp_valid  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_idx      <= w_idx_nxt;
         r_rdy_q    <= col_ready;
         smp_r      <= w_nxt_r;
         smp_i      <= w_nxt_i;
         smp_col    <= w_idx_nxt[c_IW-1];
         smp_row    <= w_idx_nxt[1:0];
         smp_valid  <= (w_state_nxt == S_STREAM);
         busy       <= (w_state_nxt == S_STREAM);
         frame_done <= w_last;
         overrun    <= overrun | w_ovr;
      end
   end

endmodule : hq_col_reader
`default_nettype wire

// File: doc/hq_col_reader.md
# hq_col_reader

Consumer end of the HqB2 column interface in the SOML decoder. Captures the four packed 64-bit column words (two columns × real/imag, four Q8.8 elements each) when the producer's `ready` completion level rises. Then streams the eight complex elements one per handshake to the downstream metric stage. Provides registered output, backpressure and overrun detection so the producer never has to stall.

## Interface
- `DW`, 16, element width (signed Q8.8)
- `ROWS`, 4, elements per column word
- `COLS`, 2, columns per frame

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-low reset (`rst`=0 resets on the next `clk` edge)
- `col0_r`, `col0_i`, `col1_r`, `col1_i`  in  ROWS*DW each  packed column words; row k occupies bits [DW*(ROWS-k)-1 : DW*(ROWS-k-1)], so row 0 sits in [63:48]
- `col_ready`  in  1  producer completion level; a frame is offered on its 0→1 transition
- `smp_r`, `smp_i`  out  DW  current element, real/imag
- `smp_col`  out  1  column index of the current element
- `smp_row`  out  2  row index of the current element
- `smp_valid`  out  1  element valid
- `smp_ready`  in  1  downstream accept
- `frame_done`  out  1  one-cycle pulse after the last element is accepted
- `busy`  out  1  high while a frame is held
- `overrun`  out  1  sticky: a frame was offered while busy and dropped

## Operation
- All outputs reset to 0. Internal state on reset: edge register `rdy_q` = 0, element index = 0, buffer = 0, state = IDLE.
- `rise` = `col_ready` & ~`rdy_q`. Because `rdy_q` resets to 0, `col_ready` high at reset release counts as a rise.
- **IDLE**
  - On `rise`: capture all four words into the buffer, set index to 0, go to STREAM.
  - Otherwise stay in IDLE.
- **STREAM**
  - `smp_valid`=1 and `busy`=1.
  - Element order by index i = 0..7: col = i[2], row = i[1:0].
  - Handshake: on `smp_valid` & `smp_ready` the element is consumed and the index increments.
  - When element 7 is consumed: pulse `frame_done`, return to IDLE.
- **Overrun**: a `rise` in STREAM that does not coincide with consumption of element 7 sets `overrun` and is ignored. The buffer is unchanged.
- **Simultaneous events**: a `rise` in the same cycle element 7 is consumed is accepted as a new frame. The buffer is recaptured, the index returns to 0, the block stays in STREAM, `frame_done` still pulses, and `overrun` is not set.
- **Output stability**: while `smp_valid`=1 and `smp_ready`=0, `smp_r`, `smp_i`, `smp_col` and `smp_row` hold steady.
- **Data path**: element bits are passed through unmodified. No arithmetic, no sign handling.
- `overrun` clears only on reset.
- **Reset mid-frame**: the frame is discarded and all outputs go to 0 on the reset edge. A `col_ready` still high after reset release is captured as a new frame.

## Timing
- `rise` detected at edge N → `smp_valid`=1 with element 0 (col 0, row 0) from N+1.
- All outputs are registered. There is no combinational path from `smp_ready` or `col_ready` to any output.
- With `smp_ready` held high, throughput is one element per cycle. Elements 0..7 appear on cycles N+1..N+8.
- `frame_done` is high on cycle N+9, and `smp_valid` is 0 on N+9 unless a new frame was accepted.
- Minimum producer-to-producer frame spacing without overrun: 8 cycles plus one cycle per stall cycle.

## Structure
- **Shared package `hq_pkg`**:
  - localparams `HQ_DW`=16, `HQ_ROWS`=4, `HQ_COLS`=2
  - state encodings `S_IDLE`, `S_STREAM`
  - helper macro or function to extract row k from a packed word
- **Sub-module `hq_col_buffer`**:
  - capture-enabled 4×64-bit register bank
  - index-selected output mux returning real/imag for (col, row)
- **Top level**: edge detector, FSM, index counter, output registers, overrun flag.

## Test plan
- **Single frame**
  - Stimulus: reset, then `col0_r`=64'h0100_FF00_0080_0000, `col0_i`=64'h0000_0040_FFC0_0100, `col1_r`=64'h00DB_FFAD_FF9C_0005, `col1_i`=64'h000C_FFEA_FF2A_FEA3; raise `col_ready` with `smp_ready`=1.
  - Required: eight elements in order (0,0) r=16'h0100 i=16'h0000 … (1,3) r=16'h0005 i=16'hFEA3; `frame_done` pulses on the 9th cycle after the rise; `busy` is high for exactly 8 cycles.
- **Backpressure**
  - Stimulus: toggle `smp_ready` 1,0,0,1,…
  - Required: no element skipped or repeated; outputs stable during stall cycles; frame completes after 8 accepted handshakes.
- **Overrun**
  - Stimulus: second `col_ready` rise at element 3 with different data.
  - Required: `overrun`=1 and remains set; remaining elements still come from the first frame.
- **Back-to-back frames**
  - Stimulus: rise coincident with consumption of element 7.
  - Required: `frame_done` pulses; element 0 of the new frame follows immediately; `overrun`=0.
- **Reset mid-frame**
  - Stimulus: `rst`=0 at element 5 while `col_ready` stays high.
  - Required: all outputs 0 during reset; after release, element 0 of the current input words appears 2 cycles later.
- **Level hold**
  - Stimulus: `col_ready` held high for 20 cycles.
  - Required: exactly one frame streamed; no overrun.
